// File: rtl/vending_fsm.sv
// Vending machine control core: credit accounting, item dispense, and
// change payout (largest coin first) driven by single-cycle input pulses.
module vending_fsm #(
    parameter int PRICE_A    = 300,
    parameter int PRICE_B    = 700,
    parameter int MAX_CREDIT = 1500,
    parameter int CREDIT_W   = 11
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin100,
    input  logic                coin500,
    input  logic                sel_a,
    input  logic                sel_b,
    input  logic                cancel,
    output logic [CREDIT_W-1:0] credit,
    output logic                dispense_a,
    output logic                dispense_b,
    output logic                change100,
    output logic                change500,
    output logic                coin_reject,
    output logic                busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CREDIT = 2'd1;
    localparam logic [1:0] S_VEND   = 2'd2;
    localparam logic [1:0] S_CHANGE = 2'd3;

    localparam logic [CREDIT_W-1:0] PA   = CREDIT_W'(PRICE_A);
    localparam logic [CREDIT_W-1:0] PB   = CREDIT_W'(PRICE_B);
    localparam logic [CREDIT_W-1:0] C100 = CREDIT_W'(100);
    localparam logic [CREDIT_W-1:0] C500 = CREDIT_W'(500);
    // Coin acceptance is checked one bit wider so the sum cannot wrap.
    localparam logic [CREDIT_W:0]   W100 = (CREDIT_W+1)'(100);
    localparam logic [CREDIT_W:0]   W500 = (CREDIT_W+1)'(500);
    localparam logic [CREDIT_W:0]   WMAX = (CREDIT_W+1)'(MAX_CREDIT);

    logic [1:0]          state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                disp_a_q, disp_a_d;
    logic                disp_b_q, disp_b_d;
    logic                chg100_q, chg100_d;
    logic                chg500_q, chg500_d;
    logic                reject_q, reject_d;

    logic                coin_any, coin_both;
    logic [CREDIT_W:0]   coin_sum;

    assign coin_any  = coin100 | coin500;
    assign coin_both = coin100 & coin500;
    assign coin_sum  = {1'b0, credit_q} + (coin500 ? W500 : W100);

    // Next-state and pulse generation; pulses default low so each lasts one cycle.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        disp_a_d = 1'b0;
        disp_b_d = 1'b0;
        chg100_d = 1'b0;
        chg500_d = 1'b0;
        reject_d = 1'b0;
        case (state_q)
            S_IDLE, S_CREDIT: begin
                if (cancel && credit_q != '0) begin
                    state_d  = S_CHANGE;
                    reject_d = coin_any;
                end else if (sel_a && !sel_b && credit_q >= PA) begin
                    credit_d = credit_q - PA;
                    disp_a_d = 1'b1;
                    state_d  = S_VEND;
                    reject_d = coin_any;
                end else if (sel_b && !sel_a && credit_q >= PB) begin
                    credit_d = credit_q - PB;
                    disp_b_d = 1'b1;
                    state_d  = S_VEND;
                    reject_d = coin_any;
                end else if (coin_both) begin
                    reject_d = 1'b1;
                end else if (coin_any) begin
                    if (coin_sum <= WMAX) begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                        state_d  = S_CREDIT;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            S_VEND: begin
                reject_d = coin_any;
                state_d  = (credit_q == '0) ? S_IDLE : S_CHANGE;
            end
            S_CHANGE: begin
                reject_d = coin_any;
                if (credit_q >= C500) begin
                    credit_d = credit_q - C500;
                    chg500_d = 1'b1;
                end else if (credit_q >= C100) begin
                    credit_d = credit_q - C100;
                    chg100_d = 1'b1;
                end else begin
                    // Sub-100 residue cannot occur; drop it rather than hang.
                    credit_d = '0;
                end
                if (credit_d == '0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, balance and registered output pulses; reset aborts any payout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            credit_q <= '0;
            disp_a_q <= 1'b0;
            disp_b_q <= 1'b0;
            chg100_q <= 1'b0;
            chg500_q <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            disp_a_q <= disp_a_d;
            disp_b_q <= disp_b_d;
            chg100_q <= chg100_d;
            chg500_q <= chg500_d;
            reject_q <= reject_d;
        end
    end

    assign credit      = credit_q;
    assign dispense_a  = disp_a_q;
    assign dispense_b  = disp_b_q;
    assign change100   = chg100_q;
    assign change500   = chg500_q;
    assign coin_reject = reject_q;
    assign busy        = (state_q == S_VEND) || (state_q == S_CHANGE);

endmodule

// File: tb/tb_vending_fsm.sv
// Bench for vending_fsm: directed scenarios plus random pulses, checked each
// cycle against a queue-based payout model.
module tb_vending_fsm;

    localparam int PRICE_A = 300;
    localparam int PRICE_B = 700;
    localparam int MAXC    = 1500;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        coin100 = 1'b0, coin500 = 1'b0, sel_a = 1'b0, sel_b = 1'b0, cancel = 1'b0;
    logic [10:0] credit;
    logic        dispense_a, dispense_b, change100, change500, coin_reject, busy;

    int checks = 0;
    int failures = 0;

    vending_fsm #(.PRICE_A(PRICE_A), .PRICE_B(PRICE_B), .MAX_CREDIT(MAXC), .CREDIT_W(11)) dut (
        .clk(clk), .rst_n(rst_n),
        .coin100(coin100), .coin500(coin500), .sel_a(sel_a), .sel_b(sel_b), .cancel(cancel),
        .credit(credit), .dispense_a(dispense_a), .dispense_b(dispense_b),
        .change100(change100), .change500(change500), .coin_reject(coin_reject), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model: balance plus a queue of pending payout events (0 = vend gap cycle).
    int m_credit;
    int m_q[$];
    logic m_da, m_db, m_c100, m_c500, m_rej;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%0d expected=%0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_credit = 0;
        m_q.delete();
        {m_da, m_db, m_c100, m_c500, m_rej} = '0;
    endtask

    task automatic push_change(input int c);
        for (int i = 0; i < c / 500; i++) m_q.push_back(500);
        for (int i = 0; i < (c % 500) / 100; i++) m_q.push_back(100);
    endtask

    task automatic model_step();
        int v;
        bit coin;
        {m_da, m_db, m_c100, m_c500, m_rej} = '0;
        coin = coin100 | coin500;
        if (!rst_n) begin
            model_reset();
        end else if (m_q.size() > 0) begin
            m_rej = coin;
            v = m_q.pop_front();
            if (v == 500) m_c500 = 1'b1;
            if (v == 100) m_c100 = 1'b1;
            m_credit -= v;
        end else if (cancel && m_credit > 0) begin
            m_rej = coin;
            push_change(m_credit);
        end else if (sel_a && !sel_b && m_credit >= PRICE_A) begin
            m_rej = coin;
            m_da = 1'b1;
            m_credit -= PRICE_A;
            m_q.push_back(0);
            push_change(m_credit);
        end else if (sel_b && !sel_a && m_credit >= PRICE_B) begin
            m_rej = coin;
            m_db = 1'b1;
            m_credit -= PRICE_B;
            m_q.push_back(0);
            push_change(m_credit);
        end else if (coin100 && coin500) begin
            m_rej = 1'b1;
        end else if (coin) begin
            v = coin500 ? 500 : 100;
            if (m_credit + v <= MAXC) m_credit += v;
            else m_rej = 1'b1;
        end
    endtask

    task automatic compare();
        chk("credit", 32'(credit), 32'(m_credit));
        chk("pulses_busy", {26'd0, dispense_a, dispense_b, change100, change500, coin_reject, busy},
            {26'd0, m_da, m_db, m_c100, m_c500, m_rej, (m_q.size() > 0)});
    endtask

    // One clock: drive pulses from a negedge, step model at posedge, check at next negedge.
    task automatic cyc(input logic c1, input logic c5, input logic sa, input logic sb, input logic cn);
        coin100 = c1; coin500 = c5; sel_a = sa; sel_b = sb; cancel = cn;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
        {coin100, coin500, sel_a, sel_b, cancel} = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        {coin100, coin500, sel_a, sel_b, cancel} = '0;
        #1;
        model_reset();
        compare();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
        rst_n = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        chk("reset_credit", 32'(credit), 0);
        chk("reset_busy", 32'(busy), 0);

        // Coins then sel_a: dispense, vend gap, three 100 change pulses.
        cyc(0, 1, 0, 0, 0);
        idle(1);
        cyc(1, 0, 0, 0, 0);
        chk("plan1_600", 32'(credit), 600);
        cyc(0, 0, 1, 0, 0);
        chk("plan1_disp", {dispense_a, 11'(credit)}, {1'b1, 11'd300});
        idle(4);
        chk("plan1_end", {busy, 11'(credit)}, {1'b0, 11'd0});

        // 1200 then cancel: 500,500,100,100.
        cyc(0, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0); cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0);
        chk("plan2_1200", 32'(credit), 1200);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        chk("plan2_c500", 32'(change500), 1);
        idle(3);
        chk("plan2_end", {change100, 11'(credit)}, {1'b1, 11'd0});

        // Full credit: coin rejected; then sel_b and change 500,100,100,100.
        cyc(0, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("plan3_reject", {coin_reject, 11'(credit)}, {1'b1, 11'd1500});
        cyc(0, 0, 0, 1, 0);
        chk("plan3_disp", {dispense_b, 11'(credit)}, {1'b1, 11'd800});
        idle(6);

        // Insufficient select; simultaneous coins rejected.
        cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        chk("plan4_nosel", {dispense_a, 11'(credit)}, {1'b0, 11'd200});
        cyc(1, 1, 0, 0, 0);
        chk("plan4_both", {coin_reject, 11'(credit)}, {1'b1, 11'd200});
        cyc(0, 0, 0, 0, 1);
        idle(3);

        // Coin/select during CHANGE from 1200.
        cyc(0, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0); cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 1, 1, 0, 0);
        chk("plan5_rej", {coin_reject, change500, dispense_a}, 3'b110);
        idle(4);

        // Reset mid-CHANGE at 700.
        cyc(0, 1, 0, 0, 0); cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        chk("plan6_mid", 32'(credit), 200);
        do_reset();
        idle(2);
        chk("plan6_quiet", {change100, change500, 11'(credit)}, 13'd0);
        cyc(1, 0, 0, 0, 0);
        chk("plan6_coin", 32'(credit), 100);

        // Random pulses with occasional resets.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                cyc($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 29) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vending_fsm.md
Name: vending_fsm

Overview:
- Vending machine control core, sitting directly downstream of the per-button edge/debounce stages.
- Consumes their single-cycle pulses (two coin slots, two item selects, cancel), keeps a credit balance, and issues a dispense pulse per vend.
- Returns change as a train of one-cycle coin pulses, largest denomination first.
- Fully synchronous to clk, except for the asynchronous reset.

Parameters:
- PRICE_A, 300: price of item A in currency units; must be a multiple of 100 and ≤ MAX_CREDIT.
- PRICE_B, 700: price of item B; same constraints as PRICE_A.
- MAX_CREDIT, 1500: highest balance allowed; must be a multiple of 100.
- CREDIT_W, 11: width of the credit register; 2^CREDIT_W must exceed MAX_CREDIT+500.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- coin100  in  1  one-cycle pulse: 100-unit coin inserted.
- coin500  in  1  one-cycle pulse: 500-unit coin inserted.
- sel_a  in  1  one-cycle pulse: item A requested.
- sel_b  in  1  one-cycle pulse: item B requested.
- cancel  in  1  one-cycle pulse: return all credit.
- credit  out  CREDIT_W  current balance; registered.
- dispense_a  out  1  one-cycle pulse: release item A.
- dispense_b  out  1  one-cycle pulse: release item B.
- change100  out  1  one-cycle pulse: eject one 100 coin.
- change500  out  1  one-cycle pulse: eject one 500 coin.
- coin_reject  out  1  one-cycle pulse: inserted coin returned without being credited.
- busy  out  1  high while in VEND or CHANGE (state decode).

Behaviour:
- Reset (rst_n=0, async): state=IDLE, credit=0, all pulse outputs 0, busy=0.
  - Reset mid-VEND or mid-CHANGE aborts immediately; pending change is discarded.
- States:
  - IDLE: credit==0.
  - CREDIT: credit>0, accepting inputs.
  - VEND: one cycle.
  - CHANGE: paying out.
- All pulse outputs are registered and high for exactly one cycle.
  - An input sampled at edge k produces its output pulse during cycle k..k+1.
  - credit reflects the update from edge k.
- IDLE/CREDIT, per-edge priority:
  - 1. cancel: if credit>0, go to CHANGE; in IDLE it is a no-op.
  - 2. Select: sel_a with credit≥PRICE_A sets credit-=PRICE_A, dispense_a=1, state=VEND. sel_b behaves the same way with PRICE_B.
    - Insufficient credit: the select is ignored and nothing changes.
    - sel_a and sel_b together: both ignored.
  - 3. Coin: accepted if credit+value ≤ MAX_CREDIT; credit increases and IDLE→CREDIT. Otherwise coin_reject=1 and credit is unchanged.
- Coin reject cases (coin_reject=1):
  - coin100 and coin500 in the same cycle: both rejected, credit unchanged.
  - A coin arriving in the same cycle as an accepted cancel or select.
  - Any coin arriving in VEND or CHANGE.
- Selects and cancel in VEND or CHANGE are ignored.
- VEND: next edge goes to IDLE if credit==0, otherwise to CHANGE.
  - The remaining balance is always returned automatically; no multi-vend.
- CHANGE, each edge:
  - If credit≥500: change500=1, credit-=500.
  - Else if credit≥100: change100=1, credit-=100.
  - The edge on which credit reaches 0 also moves the state to IDLE, so the last change pulse is visible in the first IDLE cycle.
- Arithmetic: credit is unsigned and never negative. Overflow is impossible by construction (the MAX_CREDIT check is done at CREDIT_W+1 bits).
- At most one of dispense_a/dispense_b/change100/change500 is high in any cycle.

Test Plan:
- coin500, then coin100 (gap ≥1 cycle), then sel_a:
  - credit 500 → 600.
  - dispense_a pulses once and credit=300.
  - Then change100 pulses on 3 consecutive cycles, credit goes 200/100/0, and the state ends in IDLE with busy=0.
- Insert 500,500,100,100 (credit=1200), then cancel:
  - change500, change500, change100, change100 on 4 consecutive cycles.
  - No dispense; credit ends at 0.
- credit=1500, then coin100 → coin_reject pulses once and credit stays 1500. sel_b → dispense_b, credit=800, change 500 then 100,100,100.
- credit=200, then sel_a → no response and credit stays 200. coin100 and coin500 in the same cycle → coin_reject=1 and credit stays 200.
- During CHANGE from 1200, pulse coin500 and sel_a → coin_reject=1, select ignored, change sequence unchanged.
- rst_n low for 1 cycle mid-CHANGE (credit=700) → credit=0, IDLE, no further change pulses. A subsequent coin100 gives credit=100.
